// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, FSM states and port ids
// for the data-RAM arbiter and its users.
package mem_map_pkg;

    localparam int DEF_DEPTH    = 64;
    localparam int DEF_HEX_ADDR = 110;
    localparam int DEF_BTN_ADDR = 111;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous RAM, registered read, no reset.
// Read returns the old word when written in the same cycle.
module ram_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for two requesters onto the data RAM,
// with display/button MMIO and a sequential clear engine.
module ram_port_arbiter
    import mem_map_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int HEX_ADDR = DEF_HEX_ADDR,
    parameter int BTN_ADDR = DEF_BTN_ADDR
) (
    input  logic              clk,
    input  logic              res,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [1:0]        btn,
    output logic [DATA_W-1:0] hex_out
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam addr_t HEX_A = addr_t'(HEX_ADDR);
    localparam addr_t BTN_A = addr_t'(BTN_ADDR);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_W = AW'(DEPTH - 1);

    state_t state, state_nx;
    port_t  last;
    logic [AW-1:0] cnt;

    logic  gnt, g_we, g_hex, g_btn, g_ram;
    addr_t g_addr;
    data_t g_wdata, mmio_rd;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    data_t         ram_wdata, ram_q;

    logic  a_src_ram, b_src_ram;
    data_t a_mmio_q, b_mmio_q, a_hold, b_hold;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // clr_req wins over both requesters in the same cycle
    always_comb begin
        state_nx = state;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nx = ST_CLEAR;
                end else begin
                    a_gnt = a_req & (~b_req | (last == PORT_B));
                    b_gnt = b_req & (~a_req | (last == PORT_A));
                end
            end
            ST_CLEAR: begin
                if (cnt == LAST_W) begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    assign clr_busy = (state == ST_CLEAR);
    assign gnt      = a_gnt | b_gnt;
    assign g_we     = b_gnt ? b_we    : a_we;
    assign g_addr   = b_gnt ? b_addr  : a_addr;
    assign g_wdata  = b_gnt ? b_wdata : a_wdata;

    assign g_hex = (g_addr == HEX_A);
    assign g_btn = (g_addr == BTN_A);
    assign g_ram = ~g_hex & ~g_btn & ({1'b0, g_addr} < DEPTH_X);

    always_comb begin
        mmio_rd = '0;
        if (g_btn) begin
            mmio_rd = {{(DATA_W-2){1'b0}}, ~btn};
        end else if (g_hex) begin
            mmio_rd = hex_out;
        end
    end

    always_comb begin
        ram_we    = gnt & g_we & g_ram;
        ram_addr  = g_addr[AW-1:0];
        ram_wdata = g_wdata;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = cnt;
            ram_wdata = '0;
        end
    end

    ram_array #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_q)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            last    <= PORT_B;
            cnt     <= '0;
            hex_out <= '0;
        end else begin
            if (state == ST_IDLE && clr_req) begin
                hex_out <= '0;
            end else if (gnt && g_we && g_hex) begin
                hex_out <= g_wdata;
            end
            if (a_gnt) begin
                last <= PORT_A;
            end else if (b_gnt) begin
                last <= PORT_B;
            end
            cnt <= (state == ST_CLEAR) ? cnt + 1'b1 : '0;
        end
    end

    // rdata is live from the RAM/MMIO capture in the rvalid
    // cycle, then frozen in the hold register until next read
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            a_rvalid  <= 1'b0;
            a_src_ram <= 1'b0;
            a_mmio_q  <= '0;
            a_hold    <= '0;
        end else begin
            a_rvalid <= a_gnt & ~a_we;
            if (a_gnt && !a_we) begin
                a_src_ram <= g_ram;
                a_mmio_q  <= mmio_rd;
            end
            if (a_rvalid) begin
                a_hold <= a_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            b_rvalid  <= 1'b0;
            b_src_ram <= 1'b0;
            b_mmio_q  <= '0;
            b_hold    <= '0;
        end else begin
            b_rvalid <= b_gnt & ~b_we;
            if (b_gnt && !b_we) begin
                b_src_ram <= g_ram;
                b_mmio_q  <= mmio_rd;
            end
            if (b_rvalid) begin
                b_hold <= b_rdata;
            end
        end
    end

    assign a_rdata = a_rvalid ? (a_src_ram ? ram_q : a_mmio_q) : a_hold;
    assign b_rdata = b_rvalid ? (b_src_ram ? ram_q : b_mmio_q) : b_hold;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a reference model
// predicts read data at grant time, a monitor checks rvalid.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic        a_req, a_we, b_req, b_we;
    logic [11:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata, hex_out;
    logic        clr_req, clr_busy;
    logic [1:0]  btn;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mdl [64];
    logic [15:0] hexm;
    logic [15:0] aq [$];
    logic [15:0] bq [$];

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk     (clk),
        .res     (res),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_gnt   (a_gnt),
        .a_rvalid(a_rvalid),
        .a_rdata (a_rdata),
        .b_req   (b_req),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_gnt   (b_gnt),
        .b_rvalid(b_rvalid),
        .b_rdata (b_rdata),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .btn     (btn),
        .hex_out (hex_out)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mrd(input int addr);
        if (addr == 111) return {14'b0, ~btn};
        if (addr == 110) return hexm;
        if (addr < 64) return mdl[addr];
        return 16'h0;
    endfunction

    function automatic void mwr(input int addr, input logic [15:0] d);
        if (addr == 110) hexm = d;
        else if (addr < 64) mdl[addr] = d;
    endfunction

    always @(negedge clk) begin
        if (a_rvalid) begin
            if (aq.size() == 0) chk("a_rv_unexp", 1, 0);
            else chk("a_rdata", a_rdata, aq.pop_front());
        end
        if (b_rvalid) begin
            if (bq.size() == 0) chk("b_rv_unexp", 1, 0);
            else chk("b_rdata", b_rdata, bq.pop_front());
        end
    end

    // entered and left at posedge+1
    task automatic acc(input bit pb, input bit we, input int addr,
                       input logic [15:0] wd);
        int  n;
        bit  g;
        n = 0;
        g = 0;
        if (pb) begin
            b_req = 1; b_we = we; b_addr = 12'(addr); b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_addr = 12'(addr); a_wdata = wd;
        end
        while (!g && n < 100) begin
            @(negedge clk);
            g = pb ? b_gnt : a_gnt;
            if (!g) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("gnt_wait", n, 0);
        if (g) begin
            if (we) mwr(addr, wd);
            else if (pb) bq.push_back(mrd(addr));
            else aq.push_back(mrd(addr));
            @(posedge clk); #1;
        end
        a_req = 0;
        b_req = 0;
        if (g && !we) begin
            @(negedge clk);
            chk("rv_lat", pb ? b_rvalid : a_rvalid, 1);
            chk("rv_other", pb ? a_rvalid : b_rvalid, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  n;
        bit  ea;
        res = 0; clr_req = 0; btn = 2'b11;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        hexm = 0;
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", {a_gnt, b_gnt}, 0);
        chk("rst_rv", {a_rvalid, b_rvalid}, 0);
        chk("rst_busy", clr_busy, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        chk("rst_hex", hex_out, 0);
        @(posedge clk); #1;
        res = 1;
        @(posedge clk); #1;

        acc(0, 1, 5, 16'h1234);
        acc(0, 0, 5, 0);
        repeat (2) @(negedge clk);
        chk("a_hold", a_rdata, 16'h1234);
        @(posedge clk); #1;

        // contention: last grant before this is B, so A first
        acc(0, 1, 1, 16'h1111);
        acc(1, 1, 2, 16'h2222);
        a_req = 1; a_we = 0; a_addr = 1;
        b_req = 1; b_we = 0; b_addr = 2;
        ea = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_a", a_gnt, ea);
            chk("rr_b", b_gnt, !ea);
            if (a_gnt) aq.push_back(mrd(1));
            if (b_gnt) bq.push_back(mrd(2));
            ea = !ea;
            @(posedge clk); #1;
        end
        a_req = 0; b_req = 0;
        repeat (2) @(posedge clk); #1;

        // MMIO
        acc(0, 1, 46, 16'h4646);
        acc(0, 1, 110, 16'hBEEF);
        @(negedge clk);
        chk("hex_w", hex_out, 16'hBEEF);
        @(posedge clk); #1;
        acc(0, 0, 46, 0);
        btn = 2'b01;
        acc(0, 0, 111, 0);
        acc(1, 0, 110, 0);
        acc(0, 1, 6, 16'h0606);
        acc(0, 1, 70, 16'h7070);
        acc(0, 0, 70, 0);
        acc(0, 0, 6, 0);
        acc(0, 1, 47, 16'h4747);
        acc(1, 1, 111, 16'hDEAD);
        acc(0, 0, 47, 0);
        @(negedge clk);
        chk("hex_btn_w", hex_out, 16'hBEEF);
        @(posedge clk); #1;

        // back-to-back fill
        a_req = 1; a_we = 1; a_wdata = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            a_addr = 12'(i);
            @(negedge clk);
            chk("fill_gnt", a_gnt, 1);
            if (a_gnt) mwr(i, 16'hFFFF);
            @(posedge clk); #1;
        end
        a_req = 0;
        @(posedge clk); #1;

        // clear with B waiting
        clr_req = 1; b_req = 1; b_we = 0; b_addr = 3;
        @(negedge clk);
        chk("clr_nognt", {a_gnt, b_gnt}, 0);
        @(posedge clk); #1;
        clr_req = 0;
        for (int i = 0; i < 64; i++) mdl[i] = 16'h0;
        hexm = 0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (!clr_busy) break;
            if (n == 0) chk("clr_hex", hex_out, 0);
            if (b_gnt) chk("clr_b_gnt", 1, 0);
            n++;
            @(posedge clk); #1;
        end
        chk("clr_len", n, 64);
        chk("clr_b_after", b_gnt, 1);
        if (b_gnt) bq.push_back(mrd(3));
        @(posedge clk); #1;
        b_req = 0;
        @(posedge clk); #1;
        a_req = 1; a_we = 0;
        for (int i = 0; i < 64; i++) begin
            a_addr = 12'(i);
            @(negedge clk);
            chk("sweep_gnt", a_gnt, 1);
            if (a_gnt) aq.push_back(mrd(i));
            @(posedge clk); #1;
        end
        a_req = 0;
        repeat (2) @(posedge clk); #1;

        // reset during clear
        for (int i = 0; i <= 10; i++) acc(0, 1, i, 16'h7777);
        acc(0, 1, 20, 16'hA5A5);
        acc(0, 1, 110, 16'h1357);
        acc(0, 0, 20, 0);
        clr_req = 1;
        @(posedge clk); #1;
        clr_req = 0;
        repeat (10) @(posedge clk);
        #1;
        res = 0;
        for (int i = 0; i < 10; i++) mdl[i] = 16'h0;
        hexm = 0;
        @(negedge clk);
        chk("mid_busy", clr_busy, 0);
        chk("mid_rdata", a_rdata, 0);
        chk("mid_hex", hex_out, 0);
        @(posedge clk); #1;
        res = 1;
        @(posedge clk); #1;
        acc(0, 0, 0, 0);
        acc(0, 0, 9, 0);
        acc(1, 0, 10, 0);
        acc(0, 0, 20, 0);
        repeat (3) @(posedge clk);
        chk("aq_empty", aq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
